// File: rtl/instr_encoder.sv
// Packs DDR4 command records into 4x32-bit instruction slots, pairs write bundles with one 512-bit data beat.
// Latency: out_valid the cycle after bundle close (no WR) or the cycle after the wdata handshake (WR).
// Backpressure: SEND holds out_data stable until out_ready; cmd_ready/wdata_ready drop outside their accept states.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   cmd_valid/cmd_ready + cmd_* command record stream
//   wdata_valid/wdata_ready     512-bit write-data beat
//   flush                       close a non-empty partial bundle
//   out_data/out_valid/out_ready merged word {wdata, slots} toward the scheduler
//   bundles_sent                wrapping count of output handshakes
module instr_encoder #(
    parameter int BG_WIDTH   = 2,
    parameter int BANK_WIDTH = 2,
    parameter int COL_WIDTH  = 10,
    parameter int ROW_WIDTH  = 17,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_type,
    input  logic [BG_WIDTH-1:0]   cmd_bg,
    input  logic [BANK_WIDTH-1:0] cmd_bank,
    input  logic [ROW_WIDTH-1:0]  cmd_addr,
    input  logic                  cmd_pall,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    input  logic [511:0]          wdata,
    input  logic                  flush,
    output logic [639:0]          out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           bundles_sent
);

    localparam logic [2:0] T_NOP = 3'd0;
    localparam logic [2:0] T_PRE = 3'd1;
    localparam logic [2:0] T_ACT = 3'd2;
    localparam logic [2:0] T_RD  = 3'd3;
    localparam logic [2:0] T_WR  = 3'd4;
    localparam logic [2:0] T_REF = 3'd5;
    localparam logic [2:0] T_ZQ  = 3'd6;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        WAIT_WD = 2'd1,
        SEND    = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [2:0]    count_q, count_d;
    logic          has_wr_q, has_wr_d;
    logic [7:0]    timer_q, timer_d;
    logic [127:0]  slots_q, slots_d;
    logic [511:0]  wdata_q, wdata_d;
    logic [31:0]   bundles_q, bundles_d;

    logic [31:0]   slot_enc;
    logic          is_wr;
    logic          accept;
    logic          close;

    // Field widths in the slot are fixed; parameterised inputs are resized into them.
    logic [1:0]    bg_f;
    logic [1:0]    bank_f;
    assign bg_f   = 2'(cmd_bg);
    assign bank_f = 2'(cmd_bank);

    always_comb begin
        slot_enc = '0;
        case (cmd_type)
            T_PRE:        slot_enc = {8'b0, 16'b0, cmd_pall, bg_f, bank_f, cmd_type};
            T_ACT:        slot_enc = {8'b0, 17'(cmd_addr), bg_f, bank_f, cmd_type};
            T_RD, T_WR:   slot_enc = {8'b0, 17'(cmd_addr[COL_WIDTH-1:0]), bg_f, bank_f, cmd_type};
            T_NOP, T_REF,
            T_ZQ:         slot_enc = {29'b0, cmd_type};
            default:      slot_enc = '0;   // type 7 becomes a plain NOP
        endcase
    end

    assign is_wr = cmd_valid && (cmd_type == T_WR);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        has_wr_d    = has_wr_q;
        timer_d     = timer_q;
        slots_d     = slots_q;
        wdata_d     = wdata_q;
        bundles_d   = bundles_q;
        cmd_ready   = 1'b0;
        wdata_ready = 1'b0;
        out_valid   = 1'b0;
        accept      = 1'b0;
        close       = 1'b0;

        case (state_q)
            FILL: begin
                // A second WR cannot share a bundle: refuse it and close instead.
                cmd_ready = rst_n && !(has_wr_q && is_wr);
                accept    = cmd_valid && cmd_ready;

                if (accept) begin
                    slots_d[{count_q[1:0], 5'd0} +: 32] = slot_enc;
                    count_d = count_q + 3'd1;
                    if (is_wr) begin
                        has_wr_d = 1'b1;
                    end
                    timer_d = '0;
                end else if (count_q == 3'd0) begin
                    timer_d = '0;
                end else if (timer_q != 8'hFF) begin
                    timer_d = timer_q + 8'd1;
                end

                close = (accept && (count_q == 3'd3))
                     || (has_wr_q && is_wr)
                     || (flush && ((count_q != 3'd0) || accept))
                     || ((TIMEOUT != 0) && (count_q != 3'd0) && (timer_q == 8'(TIMEOUT)));

                if (close) begin
                    state_d = has_wr_d ? WAIT_WD : SEND;
                end
            end

            WAIT_WD: begin
                wdata_ready = rst_n;
                if (wdata_valid) begin
                    wdata_d = wdata;
                    state_d = SEND;
                end
            end

            SEND: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d   = FILL;
                    count_d   = '0;
                    has_wr_d  = 1'b0;
                    timer_d   = '0;
                    slots_d   = '0;
                    wdata_d   = '0;   // next bundle without WR must carry zero data
                    bundles_d = bundles_q + 32'd1;
                end
            end

            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FILL;
            count_q   <= '0;
            has_wr_q  <= 1'b0;
            timer_q   <= '0;
            slots_q   <= '0;
            wdata_q   <= '0;
            bundles_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            has_wr_q  <= has_wr_d;
            timer_q   <= timer_d;
            slots_q   <= slots_d;
            wdata_q   <= wdata_d;
            bundles_q <= bundles_d;
        end
    end

    assign out_data     = {wdata_q, slots_q};
    assign bundles_sent = bundles_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected bundles queued at stimulus time, compared on output handshake.
// Latency: checks close-to-valid and wdata-to-valid spacing, plus timeout close timing.
// Backpressure: holds out_ready low and checks out_data stability and cmd_ready gating.
module tb_instr_encoder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid, cmd_ready;
    logic [2:0]   cmd_type;
    logic [1:0]   cmd_bg, cmd_bank;
    logic [16:0]  cmd_addr;
    logic         cmd_pall;
    logic         wdata_valid, wdata_ready;
    logic [511:0] wdata;
    logic         flush;
    logic [639:0] out_data;
    logic         out_valid, out_ready;
    logic [31:0]  bundles_sent;

    // Second instance with the idle timeout disabled.
    logic         cmd_valid_nt, cmd_ready_nt, wdata_ready_nt, flush_nt, out_valid_nt;
    logic [639:0] out_data_nt;
    logic [31:0]  bundles_nt;

    always #5 clk = ~clk;

    instr_encoder #(.TIMEOUT(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_bg(cmd_bg), .cmd_bank(cmd_bank), .cmd_addr(cmd_addr), .cmd_pall(cmd_pall),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .flush(flush), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .bundles_sent(bundles_sent)
    );

    instr_encoder #(.TIMEOUT(0)) u_dut_nt (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid_nt), .cmd_ready(cmd_ready_nt), .cmd_type(cmd_type),
        .cmd_bg(cmd_bg), .cmd_bank(cmd_bank), .cmd_addr(cmd_addr), .cmd_pall(cmd_pall),
        .wdata_valid(1'b0), .wdata_ready(wdata_ready_nt), .wdata(wdata),
        .flush(flush_nt), .out_data(out_data_nt), .out_valid(out_valid_nt), .out_ready(1'b1),
        .bundles_sent(bundles_nt)
    );

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [639:0] sb_q[$];
    logic [639:0] mon_exp;

    task automatic chk(input string tag, input logic [639:0] got, input logic [639:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [2:0] t, input logic [1:0] bg,
                                        input logic [1:0] bk, input logic [16:0] a,
                                        input logic p);
        case (t)
            3'd1:       return {8'b0, 16'b0, p, bg, bk, t};
            3'd2:       return {8'b0, a, bg, bk, t};
            3'd3, 3'd4: return {8'b0, 7'b0, a[9:0], bg, bk, t};
            3'd7:       return 32'b0;
            default:    return {29'b0, t};
        endcase
    endfunction

    // Output monitor: every handshake must match the oldest queued bundle.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_bundle", out_data, 640'(0));
            end else begin
                mon_exp = sb_q.pop_front();
                chk("bundle", out_data, mon_exp);
            end
        end
    end

    task automatic send_cmd(input logic [2:0] t, input logic [1:0] bg, input logic [1:0] bk,
                            input logic [16:0] a, input logic p);
        int n;
        cmd_type = t; cmd_bg = bg; cmd_bank = bk; cmd_addr = a; cmd_pall = p;
        cmd_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_accept", 640'(cmd_ready), 640'(1));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 640'(sb_q.size()), 640'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [639:0] hold;
        logic [31:0]  act4;
        logic [511:0] w3;
        int           n, seen;

        rst_n = 1'b0; cmd_valid = 1'b1; cmd_type = 3'd0; cmd_bg = '0; cmd_bank = '0;
        cmd_addr = '0; cmd_pall = 1'b0; wdata_valid = 1'b0; wdata = '0; flush = 1'b0;
        out_ready = 1'b0; cmd_valid_nt = 1'b0; flush_nt = 1'b0;

        // Reset state
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_cmd_ready", 640'(cmd_ready), 640'(0));
        chk("rst_wdata_ready", 640'(wdata_ready), 640'(0));
        chk("rst_out_valid", 640'(out_valid), 640'(0));
        chk("rst_out_data", out_data, 640'(0));
        chk("rst_bundles", 640'(bundles_sent), 640'(0));
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_cmd_ready", 640'(cmd_ready), 640'(1));

        // Full bundle; stray write data outside WAIT_WD must be ignored
        @(posedge clk); #1;
        out_ready = 1'b1; wdata_valid = 1'b1; wdata = '1;
        sb_q.push_back({512'b0, 32'h0000_0005, 32'h0000_0081, 32'h0000_1FB3, 32'h00D5_E6B2});
        send_cmd(3'd2, 2'd1, 2'd2, 17'h1ABCD, 1'b0);
        send_cmd(3'd3, 2'd1, 2'd2, 17'h0003F, 1'b0);
        send_cmd(3'd1, 2'd0, 2'd0, 17'h00000, 1'b1);
        send_cmd(3'd5, 2'd3, 2'd1, 17'h1FFFF, 1'b0);
        @(negedge clk);
        chk("t1_out_valid", 640'(out_valid), 640'(1));
        chk("t1_wdata_ready", 640'(wdata_ready), 640'(0));
        wait_drain();
        wdata_valid = 1'b0;
        @(negedge clk);
        chk("t1_bundles", 640'(bundles_sent), 640'(1));

        // Write pairing
        @(posedge clk); #1;
        sb_q.push_back({{64{8'hA5}}, 64'b0, enc(3'd4, 2'd2, 2'd3, 17'h00010, 1'b0),
                        enc(3'd2, 2'd0, 2'd1, 17'h00123, 1'b0)});
        send_cmd(3'd2, 2'd0, 2'd1, 17'h00123, 1'b0);
        send_cmd(3'd4, 2'd2, 2'd3, 17'h00010, 1'b0);
        pulse_flush();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_wd_ready", 640'(wdata_ready), 640'(1));
            chk("t2_cmd_ready", 640'(cmd_ready), 640'(0));
            chk("t2_early_valid", 640'(out_valid), 640'(0));
            @(posedge clk); #1;
        end
        wdata = {64{8'hA5}}; wdata_valid = 1'b1;
        @(negedge clk);
        chk("t2_wd_hs_ready", 640'(wdata_ready), 640'(1));
        @(posedge clk); #1;
        wdata_valid = 1'b0;
        @(negedge clk);
        chk("t2_out_valid", 640'(out_valid), 640'(1));
        wait_drain();

        // Second-WR split with output backpressure
        out_ready = 1'b0;
        w3 = {16{32'h5A5A_C3C3}};
        wdata = w3; wdata_valid = 1'b1;
        sb_q.push_back({w3, 96'b0, enc(3'd4, 2'd1, 2'd0, 17'h00001, 1'b0)});
        sb_q.push_back({w3, 96'b0, enc(3'd4, 2'd2, 2'd1, 17'h00155, 1'b0)});
        sb_q.push_back({w3, 96'b0, enc(3'd4, 2'd3, 2'd3, 17'h1F3FF, 1'b0)});
        send_cmd(3'd4, 2'd1, 2'd0, 17'h00001, 1'b0);
        cmd_type = 3'd4; cmd_bg = 2'd2; cmd_bank = 2'd1; cmd_addr = 17'h00155;
        cmd_valid = 1'b1;
        @(negedge clk);
        chk("t3_wr2_blocked", 640'(cmd_ready), 640'(0));
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        hold = out_data;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", 640'(out_valid), 640'(1));
            chk("bp_data", out_data, hold);
            chk("bp_cmd_ready", 640'(cmd_ready), 640'(0));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send_cmd(3'd4, 2'd2, 2'd1, 17'h00155, 1'b0);
        send_cmd(3'd4, 2'd3, 2'd3, 17'h1F3FF, 1'b0);
        pulse_flush();
        wait_drain();
        wdata_valid = 1'b0; wdata = '0;
        @(negedge clk);
        chk("t3_bundles", 640'(bundles_sent), 640'(5));

        // Idle timeout (TIMEOUT=4) and timeout disabled (TIMEOUT=0)
        @(posedge clk); #1;
        act4 = enc(3'd2, 2'd2, 2'd1, 17'h0F0F0, 1'b0);
        sb_q.push_back({512'b0, 96'b0, act4});
        cmd_valid_nt = 1'b1;
        send_cmd(3'd2, 2'd2, 2'd1, 17'h0F0F0, 1'b0);
        cmd_valid_nt = 1'b0;
        n = 1;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t4_timeout_latency", 640'(n), 640'(6));
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (out_valid_nt) seen++;
        end
        chk("t4_no_timeout_quiet", 640'(seen), 640'(0));
        @(posedge clk); #1;
        flush_nt = 1'b1;
        @(posedge clk); #1;
        flush_nt = 1'b0;
        @(negedge clk);
        chk("t4_nt_valid", 640'(out_valid_nt), 640'(1));
        chk("t4_nt_data", out_data_nt, {512'b0, 96'b0, act4});
        chk("t4_sb_empty", 640'(sb_q.size()), 640'(0));

        // Flush with an empty bundle
        @(posedge clk); #1;
        pulse_flush();
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("t5_empty_flush", 640'(seen), 640'(0));
        chk("t5_bundles", 640'(bundles_sent), 640'(6));
        chk("t5_cmd_ready", 640'(cmd_ready), 640'(1));

        // Reset mid-bundle
        @(posedge clk); #1;
        send_cmd(3'd2, 2'd1, 2'd1, 17'h11111, 1'b0);
        send_cmd(3'd3, 2'd0, 2'd2, 17'h00022, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_out_valid", 640'(out_valid), 640'(0));
        chk("t6_bundles_cleared", 640'(bundles_sent), 640'(0));
        @(posedge clk); #1;
        sb_q.push_back(640'(0));
        for (int i = 0; i < 4; i++) begin
            send_cmd(3'd0, 2'd3, 2'd3, 17'h1FFFF, 1'b1);
        end
        wait_drain();
        @(negedge clk);
        chk("t6_bundles", 640'(bundles_sent), 640'(1));
        chk("end_sb_empty", 640'(sb_q.size()), 640'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
